// File: rtl/serial_frame_rx.sv
// Oversampling serial frame receiver: start bit, N data bits LSB first, optional even parity, stop bit.
// Define SERIAL_FRAME_RX_PARITY_EN to compile in the parity bit and its check.
module serial_frame_rx #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         data_in,
  output logic [N-1:0] data_out,
  output logic         valid,
  output logic         frame_error,
  output logic         parity_error,
  output logic         busy
);

  localparam int TW = (M > 1) ? $clog2(M) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [TW-1:0] TICK_HALF = TW'(M / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(M - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);

`ifdef SERIAL_FRAME_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t         state_q, state_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [N-1:0]   shift_q, shift_d;
  logic [N-1:0]   data_out_q, data_out_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           busy_q, busy_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic           perr_q, perr_d;
  logic           perr_out_q, perr_out_d;
`endif

  // Every sample point sits one tick-count after the counter reaches its terminal value,
  // so the start bit is resampled floor(M/2) edges after detection and data bits M apart.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    busy_d     = (state_q != IDLE);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    perr_d     = perr_q;
    perr_out_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!data_in) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (tick_q == TICK_HALF) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = data_in ? IDLE : DATA;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = N'({data_in, shift_q} >> 1);
          if (bit_q == BIT_LAST) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
`ifdef SERIAL_FRAME_RX_PARITY_EN
      PARITY: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          perr_d  = ^{shift_q, data_in};
          state_d = STOP;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
`endif
      STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          state_d = IDLE;
          if (data_in) begin
            data_out_d = shift_q;
            valid_d    = 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            perr_out_d = perr_q;
`endif
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      perr_q     <= 1'b0;
      perr_out_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      perr_q     <= perr_d;
      perr_out_q <= perr_out_d;
`endif
    end
  end

  assign data_out    = data_out_q;
  assign valid       = valid_q;
  assign frame_error = ferr_q;
  assign busy        = busy_q;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  assign parity_error = perr_out_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter N, default 4: number of data bits per frame.
REQ-002 Parameter M, default 4: clock cycles per serial bit; legal range M >= 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  1  serial line, idle high, synchronous to clk (no synchronizer in block).
REQ-006 data_out  output  N  last correctly framed word received.
REQ-007 valid  output  1  one-cycle pulse marking a newly updated data_out.
REQ-008 frame_error  output  1  one-cycle pulse on bad stop bit.
REQ-009 parity_error  output  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 Frame format SHALL be: start bit (0), N data bits LSB first, optional even-parity bit, stop bit (1).
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-013 IDLE: data_in sampled 0 SHALL move to START with the tick counter cleared.
REQ-014 START: at tick count floor(M/2) the line SHALL be resampled; 0 -> DATA with counter cleared; 1 -> IDLE (false start), no output pulse.
REQ-015 DATA: a bit SHALL be sampled every M cycles (mid-bit) and shifted in LSB first; after the Nth bit -> PARITY if enabled, else STOP.
REQ-016 PARITY: sampled M cycles after the last data bit; the even parity of the N data bits plus the parity bit SHALL be compared, result held until STOP.
REQ-017 STOP: sampled M cycles after the previous sample; 1 -> data_out loaded, valid pulses; 0 -> frame_error pulses, data_out unchanged, valid stays 0.
REQ-018 parity_error SHALL pulse in the same cycle as valid when the stop bit is good and parity mismatched; data_out is still updated.
REQ-019 Pulses SHALL assert on the edge the stop bit is sampled and last exactly one cycle.
REQ-020 After STOP the FSM SHALL return to IDLE on the next edge; a start bit beginning immediately after the stop-bit sample point SHALL be received without loss (back-to-back frames).
REQ-021 Tick and bit counters SHALL be sized clog2 of their terminal values and SHALL never wrap within a frame.
REQ-022 data_in SHALL be ignored outside the defined sample points in every state except IDLE.

Reset
REQ-023 reset low SHALL immediately force state IDLE, counters 0, shift register 0, data_out 0, valid/frame_error/parity_error/busy 0, regardless of frame progress.
REQ-024 After reset release, the first frame SHALL require a fresh start bit; a line already low on release is treated as a start bit.

Configuration
REQ-025 Macro SERIAL_FRAME_RX_PARITY_EN defined: PARITY state and even-parity check compiled in, frame length N+3 bits.
REQ-026 Macro undefined: PARITY state absent, frame length N+2 bits, parity_error tied 0; port list identical in both builds.

Verification (N=4, M=4, t0 = edge IDLE samples start bit)
REQ-027 Frame 0,0,1,0,1,1 (no parity) -> data_out=4'hA, valid high for one cycle at t0+22, busy high t0+1..t0+22.
REQ-028 data_in low for one cycle then high -> START resample at t0+2 sees 1, return to IDLE, no pulses, data_out unchanged.
REQ-029 Frame 4'h5 with stop bit 0 -> frame_error one-cycle pulse at t0+22, valid 0, data_out keeps prior value.
REQ-030 Back-to-back frames 4'h3 then 4'hC, second start bit directly after first stop sample -> two valid pulses, data_out 4'h3 then 4'hC.
REQ-031 reset asserted at t0+10 mid-frame -> all outputs 0 immediately; next full frame 4'h6 received correctly.
REQ-032 With SERIAL_FRAME_RX_PARITY_EN: 4'h7 with parity bit 0 -> data_out=4'h7, valid and parity_error pulse together at t0+26; parity bit 1 -> valid only.
